// File: rtl/count_event_monitor.sv
// Watches a counter's cout bus and logs WRAP/JUMP/EN_VIOL events into a FWFT FIFO (timestamps: CNT_MON_TS_EN).
// Events are written at the detecting edge; evt_valid/evt_ready drain, drops when full set sticky overflow.
module count_event_monitor #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W       = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] cout,
  input  logic              enable,
  input  logic              arm,
  input  logic              clr,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [1:0]        evt_type,
  output logic [DATA_W-1:0] evt_value,
  output logic [TS_W-1:0]   evt_ts,
  output logic [7:0]        wrap_count,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] EVT_JUMP = 2'b01;
  localparam logic [1:0] EVT_WRAP = 2'b10;
  localparam logic [1:0] EVT_VIOL = 2'b11;
`ifdef CNT_MON_TS_EN
  localparam int EW = 2 + DATA_W + TS_W;
`else
  localparam int EW = 2 + DATA_W;
`endif

  logic [DATA_W-1:0] prev_q;
  logic              prev_vld_q;
  logic              en_q;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [EW-1:0]     last_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic [7:0]        wrap_cnt_q;
  logic              ovf_q;

  logic              evt_det;
  logic [1:0]        evt_kind;
  logic [DATA_W-1:0] prev_inc;
  logic              fifo_empty, fifo_full;
  logic              push_req, push, pop, drop;
  logic [EW-1:0]     wr_entry, head, out_entry;

`ifdef CNT_MON_TS_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + TS_W'(1);
  end

  assign wr_entry = {evt_kind, cout, ts_q};
`else
  assign wr_entry = {evt_kind, cout};
`endif

  assign prev_inc = prev_q + DATA_W'(1);

  // WRAP is checked before the +1 test because FF->00 is also prev+1 modulo 2^DATA_W.
  always_comb begin
    evt_det  = 1'b0;
    evt_kind = EVT_JUMP;
    if (arm && prev_vld_q && (cout != prev_q)) begin
      if ((prev_q == '1) && (cout == '0)) begin
        evt_det  = 1'b1;
        evt_kind = EVT_WRAP;
      end else if (cout == prev_inc) begin
        evt_det  = !en_q;
        evt_kind = EVT_VIOL;
      end else begin
        evt_det  = 1'b1;
        evt_kind = EVT_JUMP;
      end
    end
  end

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign push_req   = evt_det && !clr;
  assign pop        = !fifo_empty && evt_ready && !clr;
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      en_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      wrap_cnt_q <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      prev_q     <= cout;
      prev_vld_q <= arm;
      en_q       <= enable;
      if (clr) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        cnt_q      <= '0;
        wrap_cnt_q <= '0;
        ovf_q      <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= wr_entry;
          wr_ptr_q        <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
          last_q   <= head;
        end
        cnt_q <= cnt_d;
        if (drop) ovf_q <= 1'b1;
        // Dropped wraps still count.
        if (evt_det && (evt_kind == EVT_WRAP) && (wrap_cnt_q != 8'hFF))
          wrap_cnt_q <= wrap_cnt_q + 8'd1;
      end
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_entry = fifo_empty ? last_q : head;

  assign evt_valid  = !fifo_empty;
  assign evt_type   = out_entry[EW-1 -: 2];
  assign evt_value  = out_entry[EW-3 -: DATA_W];
  assign wrap_count = wrap_cnt_q;
  assign overflow   = ovf_q;
`ifdef CNT_MON_TS_EN
  assign evt_ts = out_entry[TS_W-1:0];
`else
  assign evt_ts = '0;
`endif

endmodule

// File: tb/tb_count_event_monitor.sv
// Bench for count_event_monitor: directed scenarios plus a randomized run against a queue-based reference model.
module tb_count_event_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cout;
  logic        enable, arm, clr, evt_ready;
  logic        evt_valid;
  logic [1:0]  evt_type;
  logic [7:0]  evt_value;
  logic [11:0] evt_ts;
  logic [7:0]  wrap_count;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  count_event_monitor #(.DATA_W(8), .FIFO_DEPTH(4), .TS_W(12)) dut (
    .clk(clk), .reset(reset), .cout(cout), .enable(enable), .arm(arm), .clr(clr),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_value(evt_value), .evt_ts(evt_ts), .wrap_count(wrap_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [7:0]  v;
    logic [11:0] ts;
  } ent_t;

  // Reference model: a plain queue plus the previous sample.
  ent_t q[$];
  ent_t m_last;
  int   m_prev, m_pvld, m_en, m_ts, m_wc, m_ovf;

  wire [31:0] obs = {evt_valid, evt_type, evt_value, evt_ts, wrap_count, overflow};

  task automatic model_reset();
    q.delete();
    m_last = '{t: 2'd0, v: 8'd0, ts: 12'd0};
    m_prev = 0; m_pvld = 0; m_en = 0; m_ts = 0; m_wc = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    int   c;
    int   kind;
    ent_t e;
    c    = int'(cout);
    kind = 0;
    if (arm && m_pvld != 0 && c != m_prev) begin
      if (m_prev == 255 && c == 0)        kind = 2;
      else if (c == (m_prev + 1) % 256)   kind = (m_en != 0) ? 0 : 3;
      else                                kind = 1;
    end
    if (clr) begin
      q.delete();
      m_wc  = 0;
      m_ovf = 0;
    end else begin
      if (q.size() > 0 && evt_ready) m_last = q.pop_front();
      if (kind != 0) begin
        e = '{t: 2'(kind), v: 8'(c), ts: 12'(m_ts)};
        if (q.size() < 4) q.push_back(e);
        else              m_ovf = 1;
        if (kind == 2 && m_wc < 255) m_wc++;
      end
    end
    m_prev = c;
    m_en   = enable ? 1 : 0;
    m_pvld = arm ? 1 : 0;
    m_ts   = (m_ts + 1) % 4096;
  endtask

  function automatic logic [31:0] exp_vec();
    ent_t        h;
    logic [11:0] t;
    h = (q.size() > 0) ? q[0] : m_last;
`ifdef CNT_MON_TS_EN
    t = h.ts;
`else
    t = 12'd0;
`endif
    return {(q.size() > 0) ? 1'b1 : 1'b0, h.t, h.v, t, 8'(m_wc), m_ovf[0]};
  endfunction

  task automatic drv(input logic [7:0] c, input logic e, input logic a, input logic cl, input logic r);
    cout = c; enable = e; arm = a; clr = cl; evt_ready = r;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drv(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    n_checks++;
    if (obs !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=%h", obs, 32'h0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_no_events();
    for (int i = 0; i < 3; i++) begin
      drv(8'(i), 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      n_checks++;
      if (obs !== exp_vec() || evt_valid !== 1'b0 || wrap_count !== 8'd0) begin
        n_fail++;
        $display("FAIL no_events[%0d] got=%h want=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_jump_wrap();
    for (int c = 3; c <= 5; c++) begin
      drv(8'(c), 1'b1, 1'b1, 1'b0, 1'b1);
      step();
    end
    drv(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    n_checks++;
    if (obs !== exp_vec() || evt_valid !== 1'b1 || evt_type !== 2'b01 || evt_value !== 8'hFF) begin
      n_fail++;
      $display("FAIL jump_ff got=%h want=%h", obs, exp_vec());
    end
    drv(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    n_checks++;
    if (obs !== exp_vec() || evt_type !== 2'b10 || evt_value !== 8'h00 || wrap_count !== 8'd1) begin
      n_fail++;
      $display("FAIL wrap got=%h want=%h", obs, exp_vec());
    end
    step();
    n_checks++;
    if (obs !== exp_vec() || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_drain got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_en_viol();
    drv(8'h10, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    step();
    drv(8'h10, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    drv(8'h11, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    n_checks++;
    if (obs !== exp_vec() || evt_type !== 2'b11 || evt_value !== 8'h11) begin
      n_fail++;
      $display("FAIL en_viol got=%h want=%h", obs, exp_vec());
    end
    step();
  endtask

  task automatic test_overflow();
    logic [7:0] vals [5];
    vals = '{8'h40, 8'h80, 8'h20, 8'h90, 8'h50};
    for (int i = 0; i < 5; i++) begin
      drv(vals[i], 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      n_checks++;
      if (obs !== exp_vec() || overflow !== (i == 4)) begin
        n_fail++;
        $display("FAIL ovf_fill[%0d] got=%h want=%h", i, obs, exp_vec());
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (evt_valid !== 1'b1 || evt_value !== vals[i] || evt_type !== 2'b01) begin
        n_fail++;
        $display("FAIL ovf_order[%0d] got=%h/%h want=1/%h", i, evt_valid, evt_value, vals[i]);
      end
      drv(8'h50, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
    end
    n_checks++;
    if (obs !== exp_vec() || evt_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drained got=%h want=%h", obs, exp_vec());
    end
    drv(8'h50, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    n_checks++;
    if (obs !== exp_vec() || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] vals [4];
    vals = '{8'h30, 8'h60, 8'h30, 8'h60};
    for (int i = 0; i < 4; i++) begin
      drv(vals[i], 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    drv(8'hA0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    n_checks++;
    if (obs !== exp_vec() || overflow !== 1'b0 || evt_value !== 8'h60 || q.size() != 4) begin
      n_fail++;
      $display("FAIL full_push_pop got=%h want=%h", obs, exp_vec());
    end
    drv(8'hA0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    n_checks++;
    if (obs !== exp_vec() || evt_valid !== 1'b0 || wrap_count !== 8'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_clr got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] vals [3];
    vals = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      drv(vals[i], 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    drv(8'h33, 1'b1, 1'b1, 1'b0, 1'b1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (evt_valid !== 1'b0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid got=%h want=%h", obs, exp_vec());
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    drv(8'h77, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    n_checks++;
    if (obs !== exp_vec() || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rearm_baseline got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    int         r;
    logic [7:0] c;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      c = cout + 8'd1;
      else if (r < 60) c = 8'hFF;
      else if (r < 70) c = cout;
      else             c = 8'($urandom_range(0, 255));
      drv(c, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1));
      step();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d] got=%h want=%h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_events();
    test_jump_wrap();
    test_en_viol();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
